// File: rtl/protected_register_bank.sv
// Bank of DEPTH owned registers: claim/read/write/release with a registered response and saturating fault count.
// Optional shared-read support when PROTECTED_REGISTER_BANK_SHARED_READ_EN is defined.
module protected_register_bank #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned ID_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic [1:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [ID_WIDTH-1:0]   req_id,
   input  logic [WIDTH-1:0]      req_wdata,
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
   input  logic                  req_share,
`endif
   output logic                  resp_valid,
   output logic [WIDTH-1:0]      resp_rdata,
   output logic                  resp_fault,
   output logic [7:0]            fault_count
);

   localparam logic [1:0] OP_READ    = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b01;
   localparam logic [1:0] OP_CLAIM   = 2'b10;
   localparam logic [1:0] OP_RELEASE = 2'b11;
   localparam logic [7:0] FAULT_MAX  = 8'hFF;

   typedef enum logic {
      ST_FREE  = 1'b0,
      ST_OWNED = 1'b1
   } entry_state_t;

   entry_state_t          r_state [DEPTH];
   logic [ID_WIDTH-1:0]   r_owner [DEPTH];
   logic [WIDTH-1:0]      r_data  [DEPTH];
   entry_state_t          w_state_nxt [DEPTH];
   logic [ID_WIDTH-1:0]   w_owner_nxt [DEPTH];
   logic [WIDTH-1:0]      w_data_nxt  [DEPTH];
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
   logic [DEPTH-1:0]      r_shared;
   logic [DEPTH-1:0]      w_shared_nxt;
   logic                  w_sel_shared;
`endif

   logic                  r_resp_valid;
   logic [WIDTH-1:0]      r_resp_rdata;
   logic                  r_resp_fault;
   logic [7:0]            r_fault_count;

   logic [DEPTH-1:0]      w_sel;
   logic                  w_in_range;
   entry_state_t          w_sel_state;
   logic [ID_WIDTH-1:0]   w_sel_owner;
   logic [WIDTH-1:0]      w_sel_data;
   logic                  w_is_owner;
   logic                  w_read_ok;
   logic                  w_do_claim;
   logic                  w_do_release;
   logic                  w_do_write;
   logic                  w_fault;
   logic [WIDTH-1:0]      w_rdata;

   // Next-state for every entry plus the response that will be registered.
   always_comb begin
      w_sel        = '0;
      w_in_range   = 1'b0;
      w_sel_state  = ST_FREE;
      w_sel_owner  = '0;
      w_sel_data   = '0;
      w_is_owner   = 1'b0;
      w_read_ok    = 1'b0;
      w_do_claim   = 1'b0;
      w_do_release = 1'b0;
      w_do_write   = 1'b0;
      w_fault      = 1'b0;
      w_rdata      = '0;
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_data_nxt   = r_data;
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
      w_sel_shared = 1'b0;
      w_shared_nxt = r_shared;
`endif

      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (req_addr == ADDR_WIDTH'(i)) begin
            w_sel[i]    = 1'b1;
            w_in_range  = 1'b1;
            w_sel_state = r_state[i];
            w_sel_owner = r_owner[i];
            w_sel_data  = r_data[i];
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
            w_sel_shared = r_shared[i];
`endif
         end
      end

      w_is_owner = (w_sel_state == ST_OWNED) && (w_sel_owner == req_id);
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
      w_read_ok  = w_is_owner || ((w_sel_state == ST_OWNED) && w_sel_shared);
`else
      w_read_ok  = w_is_owner;
`endif

      if (req_valid) begin
         if (!w_in_range) begin
            w_fault = 1'b1;
         end else begin
            case (req_op)
               OP_READ: begin
                  if (w_read_ok) w_rdata = w_sel_data;
                  else           w_fault = 1'b1;
               end
               OP_WRITE: begin
                  if (w_is_owner) w_do_write = 1'b1;
                  else            w_fault    = 1'b1;
               end
               OP_CLAIM: begin
                  if (w_sel_state == ST_FREE) w_do_claim = 1'b1;
                  else                        w_fault    = 1'b1;
               end
               OP_RELEASE: begin
                  if (w_is_owner) w_do_release = 1'b1;
                  else            w_fault      = 1'b1;
               end
               default: w_fault = 1'b1;
            endcase
         end
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (w_sel[i]) begin
            if (w_do_claim) begin
               w_state_nxt[i] = ST_OWNED;
               w_owner_nxt[i] = req_id;
               w_data_nxt[i]  = '0;
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
               w_shared_nxt[i] = req_share;
`endif
            end
            if (w_do_release) begin
               w_state_nxt[i] = ST_FREE;
               w_owner_nxt[i] = '0;
               w_data_nxt[i]  = '0;
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
               w_shared_nxt[i] = 1'b0;
`endif
            end
            if (w_do_write) w_data_nxt[i] = req_wdata;
         end
      end
   end

   // Entry state and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_state[i] <= ST_FREE;
            r_owner[i] <= '0;
            r_data[i]  <= '0;
         end
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
         r_shared      <= '0;
`endif
         r_resp_valid  <= 1'b0;
         r_resp_rdata  <= '0;
         r_resp_fault  <= 1'b0;
         r_fault_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_data  <= w_data_nxt;
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
         r_shared <= w_shared_nxt;
`endif
         r_resp_valid <= req_valid;
         r_resp_rdata <= w_rdata;
         r_resp_fault <= w_fault;
         if (w_fault && (r_fault_count != FAULT_MAX))
            r_fault_count <= r_fault_count + 8'd1;
      end
   end

   assign resp_valid  = r_resp_valid;
   assign resp_rdata  = r_resp_rdata;
   assign resp_fault  = r_resp_fault;
   assign fault_count = r_fault_count;

endmodule

// File: tb/tb_protected_register_bank.sv
// Directed bench for protected_register_bank, built with DEPTH=3 so one address is out of range.
module tb_protected_register_bank;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned DEPTH      = 3;
   localparam int unsigned ADDR_WIDTH = 2;
   localparam int unsigned ID_WIDTH   = 4;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_CL  = 2'b10;
   localparam logic [1:0] OP_REL = 2'b11;

   logic                  clk;
   logic                  rst_n;
   logic                  req_valid;
   logic [1:0]            req_op;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [ID_WIDTH-1:0]   req_id;
   logic [WIDTH-1:0]      req_wdata;
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
   logic                  req_share;
`endif
   logic                  resp_valid;
   logic [WIDTH-1:0]      resp_rdata;
   logic                  resp_fault;
   logic [7:0]            fault_count;

   int errors = 0;
   int checks = 0;

   protected_register_bank #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_id     (req_id),
      .req_wdata  (req_wdata),
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
      .req_share  (req_share),
`endif
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .fault_count(fault_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request, then sample its response 1ns after the capturing edge.
   task automatic do_req(input logic [1:0] op, input logic [1:0] addr,
                         input logic [3:0] id, input logic [7:0] wd);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_id    = id;
      req_wdata = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
      checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", resp_rdata); end
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", resp_fault); end
      checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL reset_fcount got %0d want 0", fault_count); end
   endtask

   task automatic test_claim_read();
      do_req(OP_CL, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL claim_valid got %b want 1", resp_valid); end
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL claim_fault got %b want 0", resp_fault); end
      do_req(OP_RD, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL claim_read_fault got %b want 0", resp_fault); end
      checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL claim_read_rdata got %h want 00", resp_rdata); end
      checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL claim_fcount got %0d want 0", fault_count); end
   endtask

   task automatic test_back_to_back();
      do_req(OP_WR, 2'd1, 4'd3, 8'hA5);
      checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL write_rdata got %h want 00", resp_rdata); end
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL write_fault got %b want 0", resp_fault); end
      do_req(OP_RD, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_rdata !== 8'hA5) begin errors++; $display("FAIL b2b_read_rdata got %h want a5", resp_rdata); end
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL b2b_read_fault got %b want 0", resp_fault); end
      do_req(OP_RD, 2'd1, 4'd5, 8'h00);
      checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL foreign_read_rdata got %h want 00", resp_rdata); end
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL foreign_read_fault got %b want 1", resp_fault); end
      checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL foreign_read_fcount got %0d want 1", fault_count); end
   endtask

   task automatic test_ownership();
      do_req(OP_WR, 2'd1, 4'd5, 8'hFF);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL foreign_write_fault got %b want 1", resp_fault); end
      do_req(OP_REL, 2'd1, 4'd5, 8'h00);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL foreign_release_fault got %b want 1", resp_fault); end
      do_req(OP_RD, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_rdata !== 8'hA5) begin errors++; $display("FAIL kept_data got %h want a5", resp_rdata); end
      checks++; if (fault_count !== 8'd3) begin errors++; $display("FAIL own_fcount got %0d want 3", fault_count); end
      do_req(OP_REL, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL owner_release_fault got %b want 0", resp_fault); end
      do_req(OP_CL, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL reclaim_fault got %b want 0", resp_fault); end
      do_req(OP_RD, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL scrub_rdata got %h want 00", resp_rdata); end
      do_req(OP_CL, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL owner_reclaim_fault got %b want 1", resp_fault); end
      checks++; if (fault_count !== 8'd4) begin errors++; $display("FAIL reclaim_fcount got %0d want 4", fault_count); end
   endtask

   task automatic test_out_of_range();
      do_req(OP_CL, 2'd3, 4'd1, 8'h00);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL oor_claim_fault got %b want 1", resp_fault); end
      do_req(OP_RD, 2'd3, 4'd1, 8'h00);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL oor_read_fault got %b want 1", resp_fault); end
      checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL oor_read_rdata got %h want 00", resp_rdata); end
      do_req(OP_CL, 2'd0, 4'd1, 8'h00);
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL oor_entry0_free got %b want 0", resp_fault); end
      do_req(OP_RD, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL oor_entry1_owned got %b want 0", resp_fault); end
      checks++; if (fault_count !== 8'd6) begin errors++; $display("FAIL oor_fcount got %0d want 6", fault_count); end
      idle();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", resp_valid); end
      checks++; if (fault_count !== 8'd6) begin errors++; $display("FAIL idle_fcount got %0d want 6", fault_count); end
   endtask

   task automatic test_saturation();
      int bad;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         do_req(OP_RD, 2'd3, 4'd1, 8'h00);
         if ((resp_valid !== 1'b1) || (resp_fault !== 1'b1)) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL sat_stream got %0d bad responses want 0", bad); end
      checks++; if (fault_count !== 8'd255) begin errors++; $display("FAIL sat_fcount got %0d want 255", fault_count); end
      do_req(OP_WR, 2'd1, 4'd9, 8'h12);
      checks++; if (fault_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", fault_count); end
   endtask

   task automatic test_async_reset();
      do_req(OP_WR, 2'd0, 4'd1, 8'h11);
      do_req(OP_WR, 2'd0, 4'd1, 8'h22);
      #2;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", resp_valid); end
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL areset_fault got %b want 0", resp_fault); end
      checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL areset_fcount got %0d want 0", fault_count); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL areset_no_resp got %b want 0", resp_valid); end
      do_req(OP_RD, 2'd0, 4'd1, 8'h00);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL areset_e0_fault got %b want 1", resp_fault); end
      do_req(OP_RD, 2'd1, 4'd3, 8'h00);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL areset_e1_fault got %b want 1", resp_fault); end
      checks++; if (resp_rdata !== 8'h00) begin errors++; $display("FAIL areset_e1_rdata got %h want 00", resp_rdata); end
      do_req(OP_RD, 2'd2, 4'd3, 8'h00);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL areset_e2_fault got %b want 1", resp_fault); end
      checks++; if (fault_count !== 8'd3) begin errors++; $display("FAIL areset_fcount_after got %0d want 3", fault_count); end
      idle();
   endtask

`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
   task automatic test_shared_read();
      req_share = 1'b1;
      do_req(OP_CL, 2'd0, 4'd2, 8'h00);
      req_share = 1'b0;
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL share_claim_fault got %b want 0", resp_fault); end
      do_req(OP_WR, 2'd0, 4'd2, 8'h3C);
      do_req(OP_RD, 2'd0, 4'd7, 8'h00);
      checks++; if (resp_rdata !== 8'h3C) begin errors++; $display("FAIL share_read_rdata got %h want 3c", resp_rdata); end
      checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL share_read_fault got %b want 0", resp_fault); end
      do_req(OP_WR, 2'd0, 4'd7, 8'h55);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL share_write_fault got %b want 1", resp_fault); end
      do_req(OP_CL, 2'd2, 4'd2, 8'h00);
      do_req(OP_RD, 2'd2, 4'd7, 8'h00);
      checks++; if (resp_fault !== 1'b1) begin errors++; $display("FAIL private_read_fault got %b want 1", resp_fault); end
      do_req(OP_RD, 2'd0, 4'd2, 8'h00);
      checks++; if (resp_rdata !== 8'h3C) begin errors++; $display("FAIL share_owner_rdata got %h want 3c", resp_rdata); end
      checks++; if (fault_count !== 8'd5) begin errors++; $display("FAIL share_fcount got %0d want 5", fault_count); end
      idle();
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_addr  = '0;
      req_id    = '0;
      req_wdata = '0;
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
      req_share = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_claim_read();
      test_back_to_back();
      test_ownership();
      test_out_of_range();
      test_saturation();
      test_async_reset();
`ifdef PROTECTED_REGISTER_BANK_SHARED_READ_EN
      test_shared_read();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/protected_register_bank.md
Name: protected_register_bank

Overview:
- Parametrised successor to the single write-enabled register: a bank of DEPTH registers, each WIDTH bits, with per-entry ownership.
- Requesters claim an entry, and only the owner may then read or write it; release scrubs the entry.
- Single request port; registered response one cycle later, with a fault flag and a saturating fault counter.
- Sits between requesters and object storage in the permission-read path.

Parameters:
WIDTH, 8, data bits per entry
DEPTH, 4, number of entries; 1..2**ADDR_WIDTH
ADDR_WIDTH, 2, request address width
ID_WIDTH, 4, requester ID width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present this cycle
req_op  input  2  00 read, 01 write, 10 claim, 11 release
req_addr  input  ADDR_WIDTH  entry index
req_id  input  ID_WIDTH  requester ID
req_wdata  input  WIDTH  write data (op 01 only)
resp_valid  output  1  response for the request of the previous cycle
resp_rdata  output  WIDTH  read data; 0 unless the response is a successful read
resp_fault  output  1  request denied; no state change was made
fault_count  output  8  number of faulted requests, saturating

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous):
  - all entries FREE, owner 0, data 0;
  - resp_valid=0, resp_rdata=0, resp_fault=0, fault_count=0.
  - Asserting reset mid-request discards that request; no response is issued.
- Per-entry state machine: FREE <-> OWNED. Each entry also holds owner[ID_WIDTH] and data[WIDTH].
- Request handling: a request is sampled on the edge where req_valid=1. The response appears at the next edge, so resp_valid is high for exactly 1 cycle per request. No backpressure; a new request is accepted every cycle.
- Out-of-range address (req_addr >= DEPTH): always fault, no state change.
- claim (10):
  - FREE -> OWNED, owner=req_id, data=0, no fault.
  - OWNED -> fault, including re-claim by the current owner.
- release (11):
  - OWNED by req_id -> FREE, data=0, owner=0, no fault.
  - Otherwise fault.
- write (01):
  - OWNED by req_id -> data=req_wdata, no fault.
  - Otherwise fault, data unchanged.
- read (10 is claim; read is 00):
  - OWNED by req_id -> resp_rdata=data, no fault.
  - Otherwise resp_rdata=0, fault.
  - resp_rdata is 0 for every non-read op.
- Ordering: responses reflect state before the sampled request's own update. Back-to-back requests see all earlier updates; e.g. write at cycle N then read at N+1 returns the new data.
- fault_count: increments by 1 on each faulted request, in the same edge that registers resp_fault. It holds at 255, does not wrap, and is cleared only by reset.
- No state changes while req_valid=0; resp_valid returns to 0.

Optional Feature:
- Macro: PROTECTED_REGISTER_BANK_SHARED_READ_EN
- Defined:
  - Adds input port req_share (1 bit) and a per-entry shared bit.
  - A successful claim sets shared=req_share.
  - A read of an OWNED entry with shared=1 succeeds for any req_id.
  - Write, release and claim rules are unchanged.
  - Release or reset clears shared.
- Not defined: req_share port absent; non-owner reads always fault.

Test Plan:
1. Reset, then claim addr 1 id 3, then read addr 1 id 3 -> both responses fault=0; read rdata=0x00; fault_count=0.
2. id 3 writes 0xA5 to addr 1, next cycle reads it -> rdata=0xA5, fault=0. id 5 then reads addr 1 -> rdata=0x00, fault=1, fault_count=1.
3. id 5 attempts write 0xFF and release on addr 1 owned by id 3 -> both fault; id 3 read still returns 0xA5. Then id 3 releases and re-claims addr 1 -> read returns 0x00 (scrubbed).
4. DEPTH=3 build: claim addr 3 -> fault=1, no entry changes. Then 300 back-to-back faulting requests -> fault_count stops at 255.
5. Drop rst_n asynchronously mid-request with entries owned -> outputs 0 immediately. After release of reset, reads of every entry fault and no response is issued for the interrupted request.
6. With PROTECTED_REGISTER_BANK_SHARED_READ_EN: id 2 claims addr 0 with req_share=1 and writes 0x3C -> id 7 read returns 0x3C, fault=0. id 7 write to addr 0 -> fault=1.
